// File: rtl/fetch_unit.sv
// Instruction fetch unit: a START/REQ/HOLD state machine that issues one word-aligned
// read per instruction and holds the returned word until the control block advances.
// Latency: the instruction is valid one cycle after imem_ready_in. A zero-wait memory
// therefore yields one new instruction every two cycles.
// Backpressure: the unit waits in REQ until imem_ready_in, and in HOLD until pc_enable_in.
//
// Optional feature: define DELAY_SLOT_EN to get one branch delay slot. A taken redirect
// is then parked in a pending register, and the fetch after the delay slot uses it.
//
// Ports:
//   clk_in, rst_in                  clock and asynchronous active-high reset
//   pc_enable_in                    advance request, honoured only in HOLD
//   branch_taken_in/target_in       redirect, sampled only together with an accepted advance
//   imem_req_out/imem_addr_out      read request and word-aligned fetch address
//   imem_ready_in/imem_data_in      read data valid and instruction word, used only in REQ
//   instr_out/instr_valid_out       held instruction and its valid flag
//   opcode_out/func_out/code_out    combinational fields of instr_out
//   pc_out                          address of the held instruction
//   align_err_out                   one-cycle pulse on an accepted misaligned redirect
module fetch_unit #(
   parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
   input  logic        clk_in,
   input  logic        rst_in,
   input  logic        pc_enable_in,
   input  logic        branch_taken_in,
   input  logic [31:0] branch_target_in,
   output logic        imem_req_out,
   output logic [31:0] imem_addr_out,
   input  logic        imem_ready_in,
   input  logic [31:0] imem_data_in,
   output logic [31:0] instr_out,
   output logic        instr_valid_out,
   output logic [5:0]  opcode_out,
   output logic [5:0]  func_out,
   output logic [4:0]  code_out,
   output logic [31:0] pc_out,
   output logic        align_err_out
);

   localparam logic [31:0] RESET_PC_ALIGNED = {RESET_PC[31:2], 2'b00};

   typedef enum logic [1:0] {
      ST_START = 2'd0,
      ST_REQ   = 2'd1,
      ST_HOLD  = 2'd2
   } state_t;

   state_t      state_q;
   state_t      state_d;

   logic [31:0] pc_q;
   logic [31:0] instr_q;
   logic        instr_vld_q;
   logic [31:0] held_pc_q;
   logic        align_err_q;

   logic        capture;      // REQ and memory answered this cycle
   logic        advance;      // HOLD and control block asked for the next instruction
   logic        redirect;     // an accepted taken branch
   logic        misaligned;
   logic [31:0] pc_plus4;
   logic [31:0] target_aligned;
   logic [31:0] next_pc;

   // ---------------------------------------------------------------------------------
   // State register
   // ---------------------------------------------------------------------------------
   always_ff @(posedge clk_in or posedge rst_in) begin
      if (rst_in) begin
         state_q <= ST_START;
      end else begin
         state_q <= state_d;
      end
   end

   // ---------------------------------------------------------------------------------
   // Next-state and strobe decode. Inputs that do not belong to the current state are
   // simply not looked at, so a late imem_ready_in after a reset falls on the floor.
   // ---------------------------------------------------------------------------------
   always_comb begin
      state_d      = state_q;
      imem_req_out = 1'b0;
      capture      = 1'b0;
      advance      = 1'b0;
      case (state_q)
         ST_START: begin
            state_d = ST_REQ;
         end
         ST_REQ: begin
            imem_req_out = 1'b1;
            if (imem_ready_in) begin
               capture = 1'b1;
               state_d = ST_HOLD;
            end
         end
         ST_HOLD: begin
            if (pc_enable_in) begin
               advance = 1'b1;
               state_d = ST_REQ;
            end
         end
         default: begin
            state_d = ST_START;
         end
      endcase
   end

   // ---------------------------------------------------------------------------------
   // Next PC selection. The +4 wraps naturally in 32 bits.
   // ---------------------------------------------------------------------------------
   assign pc_plus4       = pc_q + 32'd4;
   assign target_aligned = {branch_target_in[31:2], 2'b00};

`ifdef DELAY_SLOT_EN
   logic        pend_vld_q;
   logic [31:0] pend_tgt_q;

   // A parked target is consumed on the advance after the delay slot. Any redirect
   // offered on that same advance is dropped, because only one target can be pending.
   assign redirect = advance & branch_taken_in & ~pend_vld_q;
   assign next_pc  = pend_vld_q ? pend_tgt_q : pc_plus4;

   always_ff @(posedge clk_in or posedge rst_in) begin
      if (rst_in) begin
         pend_vld_q <= 1'b0;
         pend_tgt_q <= 32'd0;
      end else if (advance) begin
         if (pend_vld_q) begin
            pend_vld_q <= 1'b0;
         end else if (branch_taken_in) begin
            pend_vld_q <= 1'b1;
            pend_tgt_q <= target_aligned;
         end
      end
   end
`else
   assign redirect = advance & branch_taken_in;
   assign next_pc  = branch_taken_in ? target_aligned : pc_plus4;
`endif

   assign misaligned = redirect & (branch_target_in[1:0] != 2'b00);

   // ---------------------------------------------------------------------------------
   // Datapath registers
   // ---------------------------------------------------------------------------------
   always_ff @(posedge clk_in or posedge rst_in) begin
      if (rst_in) begin
         pc_q        <= RESET_PC_ALIGNED;
         instr_q     <= 32'd0;
         instr_vld_q <= 1'b0;
         held_pc_q   <= RESET_PC_ALIGNED;
         align_err_q <= 1'b0;
      end else begin
         // A fresh value every cycle makes this a single-cycle pulse.
         align_err_q <= misaligned;
         if (capture) begin
            instr_q     <= imem_data_in;
            instr_vld_q <= 1'b1;
            held_pc_q   <= pc_q;
         end
         if (advance) begin
            pc_q        <= next_pc;
            instr_vld_q <= 1'b0;
         end
      end
   end

   // ---------------------------------------------------------------------------------
   // Outputs
   // ---------------------------------------------------------------------------------
   assign imem_addr_out   = pc_q;
   assign instr_out       = instr_q;
   assign instr_valid_out = instr_vld_q;
   assign pc_out          = held_pc_q;
   assign align_err_out   = align_err_q;

   assign opcode_out = instr_q[31:26];
   assign func_out   = instr_q[5:0];
   assign code_out   = instr_q[20:16];

endmodule
